// File: rtl/otter_io_responder.sv
// OTTER IOBUS slave: LED/switch/button registers, compare timer and latched interrupt status.
// Optional OTTER_IO_PRESCALE_EN adds a 16-bit timer prescaler in register 0x1C bits [31:16].
module otter_io_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int SW_WIDTH  = 16,
  parameter int LED_WIDTH = 16,
  parameter int BTN_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [31:0]          IOBUS_ADDR,
  input  logic [31:0]          IOBUS_OUT,
  input  logic                 IOBUS_WR,
  output logic [31:0]          IOBUS_IN,
  input  logic [SW_WIDTH-1:0]  SWITCHES,
  input  logic [BTN_WIDTH-1:0] BUTTONS,
  output logic [LED_WIDTH-1:0] LEDS,
  output logic                 INTR
);

  logic                 sel;
  logic [2:0]           idx;
  logic                 led_wr, ctrl_wr, cmp_wr, count_wr, status_wr, ien_wr;

  logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
  logic [BTN_WIDTH-1:0] btn_s1, btn_s2, btn_prev;
  logic                 btn_rise;

  logic [LED_WIDTH-1:0] led;
  logic                 en, ar, tie, ien;
  logic [31:0]          cmp, count;
  logic                 tpend, bpend;
  logic [31:0]          rd_data, rd_reg;
  logic                 intr_reg;

  logic                 tick, hit, match;
  logic [31:0]          count_n;
  logic                 en_n, tpend_n, bpend_n;
  logic [31:0]          ien_word;

  // Byte-offset bits of the address carry no information for word accesses.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^IOBUS_ADDR[1:0];

  assign sel       = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign idx       = IOBUS_ADDR[4:2];
  assign led_wr    = IOBUS_WR & sel & (idx == 3'd1);
  assign ctrl_wr   = IOBUS_WR & sel & (idx == 3'd2);
  assign cmp_wr    = IOBUS_WR & sel & (idx == 3'd3);
  assign count_wr  = IOBUS_WR & sel & (idx == 3'd4);
  assign status_wr = IOBUS_WR & sel & (idx == 3'd5);
  assign ien_wr    = IOBUS_WR & sel & (idx == 3'd7);

  assign btn_rise = |(btn_s2 & ~btn_prev);

`ifdef OTTER_IO_PRESCALE_EN
  logic [15:0] prescale, pre_cnt;

  assign tick     = (pre_cnt == prescale);
  assign ien_word = {prescale, 14'd0, ien, 1'b0};

  // Restarting on COUNT/CTRL writes gives software a deterministic first tick.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_cnt  <= 16'd0;
      prescale <= 16'd0;
    end else begin
      if (count_wr || ctrl_wr || tick)
        pre_cnt <= 16'd0;
      else
        pre_cnt <= pre_cnt + 16'd1;
      if (ien_wr)
        prescale <= IOBUS_OUT[31:16];
    end
  end
`else
  assign tick     = 1'b1;
  assign ien_word = {30'd0, ien, 1'b0};
`endif

  // A COUNT write on the match cycle suppresses the match entirely.
  always_comb begin
    hit     = tick & en & (count == cmp);
    match   = hit & ~count_wr;
    count_n = count;
    if (count_wr)
      count_n = IOBUS_OUT;
    else if (tick && en) begin
      if (hit)
        count_n = ar ? 32'd0 : count;
      else
        count_n = count + 32'd1;
    end

    en_n = en;
    if (ctrl_wr)
      en_n = IOBUS_OUT[0];
    else if (match && !ar)
      en_n = 1'b0;

    tpend_n = tpend;
    if (match)
      tpend_n = 1'b1;
    else if (status_wr && IOBUS_OUT[0])
      tpend_n = 1'b0;

    bpend_n = bpend;
    if (btn_rise)
      bpend_n = 1'b1;
    else if (status_wr && IOBUS_OUT[1])
      bpend_n = 1'b0;
  end

  always_comb begin
    rd_data = 32'd0;
    if (sel) begin
      case (idx)
        3'd0:    rd_data = 32'(sw_s2);
        3'd1:    rd_data = 32'(led);
        3'd2:    rd_data = {29'd0, tie, ar, en};
        3'd3:    rd_data = cmp;
        3'd4:    rd_data = count;
        3'd5:    rd_data = {30'd0, bpend, tpend};
        3'd6:    rd_data = 32'(btn_s2);
        default: rd_data = ien_word;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
      led      <= '0;
      en       <= 1'b0;
      ar       <= 1'b0;
      tie      <= 1'b0;
      ien      <= 1'b0;
      cmp      <= 32'd0;
      count    <= 32'd0;
      tpend    <= 1'b0;
      bpend    <= 1'b0;
      rd_reg   <= 32'd0;
      intr_reg <= 1'b0;
    end else begin
      sw_s1    <= SWITCHES;
      sw_s2    <= sw_s1;
      btn_s1   <= BUTTONS;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      if (led_wr)
        led <= IOBUS_OUT[LED_WIDTH-1:0];
      en <= en_n;
      if (ctrl_wr) begin
        ar  <= IOBUS_OUT[1];
        tie <= IOBUS_OUT[2];
      end
      if (ien_wr)
        ien <= IOBUS_OUT[1];
      if (cmp_wr)
        cmp <= IOBUS_OUT;
      count    <= count_n;
      tpend    <= tpend_n;
      bpend    <= bpend_n;
      rd_reg   <= rd_data;
      intr_reg <= (tpend & tie) | (bpend & ien);
    end
  end

  assign IOBUS_IN = rd_reg;
  assign LEDS     = led;
  assign INTR     = intr_reg;

endmodule

// File: tb/tb_otter_io_responder.sv
// Directed bench for otter_io_responder (default build, tick every cycle); reads are
// scoreboarded: expected data is queued when the address is driven and checked a cycle later.
module tb_otter_io_responder;

  localparam logic [31:0] A_SW     = 32'h1100_0000;
  localparam logic [31:0] A_LED    = 32'h1100_0004;
  localparam logic [31:0] A_CTRL   = 32'h1100_0008;
  localparam logic [31:0] A_CMP    = 32'h1100_000C;
  localparam logic [31:0] A_COUNT  = 32'h1100_0010;
  localparam logic [31:0] A_STATUS = 32'h1100_0014;
  localparam logic [31:0] A_BTN    = 32'h1100_0018;
  localparam logic [31:0] A_IEN    = 32'h1100_001C;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic [15:0] SWITCHES;
  logic [3:0]  BUTTONS;
  logic [15:0] LEDS;
  logic        INTR;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  otter_io_responder dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .SWITCHES   (SWITCHES),
    .BUTTONS    (BUTTONS),
    .LEDS       (LEDS),
    .INTR       (INTR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    logic [31:0] e;
    string t;
    @(posedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, IOBUS_IN, e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      IOBUS_ADDR = 32'h0;
      IOBUS_WR   = 1'b0;
      step();
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    step();
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = 32'h0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] expv, input string tag);
    IOBUS_ADDR = addr;
    IOBUS_WR   = 1'b0;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    step();
    IOBUS_ADDR = 32'h0;
  endtask

  initial begin
    RESET_N    = 1'b0;
    IOBUS_ADDR = 32'h0;
    IOBUS_OUT  = 32'h0;
    IOBUS_WR   = 1'b0;
    SWITCHES   = 16'h1234;
    BUTTONS    = 4'h0;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_intr", {31'd0, INTR}, 32'd0);
    check("rst_leds", {16'd0, LEDS}, 32'd0);
    check("rst_iobus_in", IOBUS_IN, 32'd0);
    RESET_N = 1'b1;
    idle(2);

    rd(A_SW,     32'h0000_1234, "rst_sw");
    rd(A_LED,    32'h0, "rst_led");
    rd(A_CTRL,   32'h0, "rst_ctrl");
    rd(A_CMP,    32'h0, "rst_cmp");
    rd(A_COUNT,  32'h0, "rst_count");
    rd(A_STATUS, 32'h0, "rst_status");
    rd(A_BTN,    32'h0, "rst_btn");
    rd(A_IEN,    32'h0, "rst_ien");
    check("rst_intr_after", {31'd0, INTR}, 32'd0);

    wr(A_LED, 32'h0000_A5A5);
    check("leds_after_wr", {16'd0, LEDS}, 32'h0000_A5A5);
    rd(A_LED, 32'h0000_A5A5, "led_read");
    wr(32'h1100_0020, 32'h0000_0000);
    rd(A_LED, 32'h0000_A5A5, "led_after_oob_wr");
    rd(32'h1100_0020, 32'h0, "oob_read");
    rd(32'h1100_0006, 32'h0000_A5A5, "led_byte_offset");

    // Auto-reload timer: COUNT walks 0..5, match, reload.
    wr(A_CMP, 32'd5);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i <= 5; i++)
      rd(A_COUNT, 32'(i), "timer_count");
    check("timer_intr_pre", {31'd0, INTR}, 32'd0);
    rd(A_COUNT, 32'd0, "timer_reload");
    check("timer_intr", {31'd0, INTR}, 32'd1);
    rd(A_STATUS, 32'h1, "timer_tpend");
    wr(A_STATUS, 32'h1);
    check("w1c_intr_hold", {31'd0, INTR}, 32'd1);
    idle(1);
    check("w1c_intr_drop", {31'd0, INTR}, 32'd0);
    wr(A_CTRL, 32'h0);

    // One-shot: holds at CMP and self-clears EN.
    wr(A_STATUS, 32'h1);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h5);
    idle(5);
    rd(A_COUNT,  32'd3, "oneshot_count");
    rd(A_CTRL,   32'h4, "oneshot_ctrl");
    rd(A_STATUS, 32'h1, "oneshot_tpend");
    check("oneshot_intr", {31'd0, INTR}, 32'd1);

    // COUNT write on the match cycle wins.
    wr(A_STATUS, 32'h1);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h1);
    idle(3);
    wr(A_COUNT, 32'h10);
    rd(A_COUNT,  32'h10, "coll_count");
    rd(A_STATUS, 32'h0,  "coll_no_tpend");
    rd(A_CTRL,   32'h1,  "coll_en_kept");

    // W1C on the match cycle: set wins.
    wr(A_CTRL, 32'h0);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h3);
    idle(2);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h1, "w1c_set_wins");
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h3);
    rd(A_STATUS, 32'h0, "status_cleared");

    // Button rising edge: BPEND at +3, INTR at +4.
    wr(A_IEN, 32'h2);
    rd(A_IEN, 32'h2, "ien_read");
    BUTTONS = 4'b0100;
    idle(2);
    rd(A_STATUS, 32'h0, "bpend_not_yet");
    check("btn_intr_pre", {31'd0, INTR}, 32'd0);
    rd(A_STATUS, 32'h2, "bpend_set");
    check("btn_intr", {31'd0, INTR}, 32'd1);
    rd(A_BTN, 32'h4, "btn_read");

    // Asynchronous reset while counting.
    wr(A_CTRL, 32'h1);
    idle(3);
    rd(A_LED, 32'h0000_A5A5, "led_before_reset");
    #3;
    RESET_N = 1'b0;
    #1;
    check("areset_leds", {16'd0, LEDS}, 32'd0);
    check("areset_intr", {31'd0, INTR}, 32'd0);
    check("areset_iobus_in", IOBUS_IN, 32'd0);
    #1;
    RESET_N = 1'b1;
    rd(A_COUNT, 32'd0, "count_after_reset");
    rd(A_CTRL,  32'd0, "ctrl_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
